cla_word_sequencer: RTL and testbench

CLA_WORD_SEQUENCER -- requirements
Module: cla_word_sequencer

---
 rtl/cla_word_sequencer.sv | 120 ++++++++++++
 tb/tb_cla_word_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_sequencer.sv
// Multi-cycle adder: adds one DWL-bit slice per cycle through a carry-lookahead
// slice; result valid WORDS cycles after accept and held until out_ready.
module cla_word_sequencer #(
  parameter int DWL   = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DWL*WORDS-1:0] a,
  input  logic [DWL*WORDS-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DWL*WORDS-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 busy
);

  localparam int W  = DWL * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_q, b_q;
  logic [DWL-1:0]  sa, sb, p, g, s;
  logic [DWL:0]    c;

  // Every carry is a flat sum-of-products of the slice's P/G terms and c0.
  function automatic logic [DWL:0] lookahead(input logic [DWL-1:0] pp,
                                             input logic [DWL-1:0] gg,
                                             input logic           c0);
    logic [DWL:0] cv;
    logic         term;
    cv    = '0;
    cv[0] = c0;
    for (int i = 0; i < DWL; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & pp[j];
      cv[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = gg[j];
        for (int k = j + 1; k <= i; k++) term = term & pp[k];
        cv[i+1] = cv[i+1] | term;
      end
    end
    return cv;
  endfunction

  always_comb begin
    sa = a_q[int'(idx)*DWL +: DWL];
    sb = b_q[int'(idx)*DWL +: DWL];
    p  = sa ^ sb;
    g  = sa & sb;
    c  = lookahead(p, g, carry);
    s  = p ^ c[DWL-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry    <= cin;
            idx      <= '0;
            state    <= ADD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ADD: begin
          sum[int'(idx)*DWL +: DWL] <= s;
          carry <= c[DWL];
          idx   <= idx + 1'b1;
          if (idx == IW'(WORDS - 1)) begin
            // s[DWL-1] is the final sum MSB, written on this same edge.
            state     <= DONE;
            cout      <= c[DWL];
            ovf       <= (a_q[W-1] == b_q[W-1]) && (s[DWL-1] != a_q[W-1]);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Bench for cla_word_sequencer: directed, randomized and control-flow scenarios
// checked against an integer-arithmetic reference model.
module tb_cla_word_sequencer;

  localparam int DWL   = 4;
  localparam int WORDS = 4;
  localparam int W     = DWL * WORDS;
  localparam int W1    = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0]  a, b, sum;
  logic          in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1, busy1;
  logic [W1-1:0] a1, b1, sum1;

  int n_checks = 0;
  int n_fail   = 0;

  cla_word_sequencer #(.DWL(DWL), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  cla_word_sequencer #(.DWL(8), .WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: unsigned total for sum/carry, signed range test for overflow.
  task automatic model(input int w, input longint ua, input longint ub, input bit c,
                       output longint s, output bit co, output bit ov);
    longint total, sa, sb, st, m;
    m     = longint'(1) << w;
    total = ua + ub + longint'(c);
    s     = total % m;
    co    = (total >= m);
    sa    = (ua >= m / 2) ? ua - m : ua;
    sb    = (ub >= m / 2) ? ub - m : ub;
    st    = sa + sb + longint'(c);
    ov    = (st > m / 2 - 1) || (st < -(m / 2));
  endtask

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input bit tc,
                         input int hold, input string name);
    longint es; bit ec, eo; int cnt;
    model(W, longint'(ta), longint'(tb_), tc, es, ec, eo);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready); end
    in_valid = 1'b1; a = ta; b = tb_; cin = tc; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy after accept: got %b want 1", name, busy); end
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    n_checks++;
    if (cnt != WORDS) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, cnt, WORDS); end
    n_checks++;
    if (sum !== W'(es) || cout !== ec || ovf !== eo) begin
      n_fail++;
      $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, W'(es), ec, eo);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== W'(es) || cout !== ec || ovf !== eo) begin
        n_fail++;
        $display("FAIL %s hold cycle %0d: got ov=%b ir=%b sum=%h want ov=1 ir=0 sum=%h",
                 name, i, out_valid, in_ready, sum, W'(es));
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== W'(es) || cout !== ec || ovf !== eo) begin
      n_fail++;
      $display("FAIL %s release: got ov=%b ir=%b busy=%b sum=%h want ov=0 ir=1 busy=0 sum=%h",
               name, out_valid, in_ready, busy, sum, W'(es));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got ir=%b ov=%b busy=%b sum=%h cout=%b ovf=%b want 1 0 0 0000 0 0",
               in_ready, out_valid, busy, sum, cout, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_txn(16'h1234, 16'h4321, 1'b0, 0, "add_1234_4321");
    run_txn(16'hFFFF, 16'h0000, 1'b1, 0, "carry_through_all");
    run_txn(16'h7FFF, 16'h0001, 1'b0, 0, "signed_overflow");
    run_txn(16'hFFFF, 16'h0001, 1'b0, 0, "wrap_ones_plus_one");
    run_txn(16'h8000, 16'h8000, 1'b0, 0, "neg_overflow");
    run_txn(16'hA5C3, 16'h5A3C, 1'b1, 5, "hold_out_ready_low");
  endtask

  task automatic test_ignore_inputs();
    logic [W-1:0] xa, xb, ya, yb; longint es; bit ec, eo; int cnt;
    xa = W'($urandom); xb = W'($urandom); ya = W'($urandom); yb = W'($urandom);
    @(negedge clk);
    in_valid = 1'b1; a = xa; b = xb; cin = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      in_valid = cnt[0]; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk); cnt++;
    end
    model(W, longint'(xa), longint'(xb), 1'b0, es, ec, eo);
    n_checks++;
    if (sum !== W'(es) || cout !== ec || ovf !== eo) begin
      n_fail++;
      $display("FAIL ignore_inputs first: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               sum, cout, ovf, W'(es), ec, eo);
    end
    in_valid = 1'b1; a = ya; b = yb; cin = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL no_accept_on_release: got ir=%b busy=%b want ir=1 busy=0", in_ready, busy);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    model(W, longint'(ya), longint'(yb), 1'b1, es, ec, eo);
    n_checks++;
    if (cnt != WORDS || sum !== W'(es) || cout !== ec) begin
      n_fail++;
      $display("FAIL ignore_inputs second: got lat=%0d sum=%h cout=%b want lat=%0d sum=%h cout=%b",
               cnt, sum, cout, WORDS, W'(es), ec);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa, xb; longint es; bit ec, eo; int prev, seen;
    xa = W'($urandom); xb = W'($urandom);
    model(W, longint'(xa), longint'(xb), 1'b1, es, ec, eo);
    @(negedge clk);
    in_valid = 1'b1; a = xa; b = xb; cin = 1'b1; out_ready = 1'b1;
    prev = -1; seen = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen++;
        n_checks++;
        if (sum !== W'(es) || cout !== ec || ovf !== eo) begin
          n_fail++; $display("FAIL b2b result: got sum=%h want %h", sum, W'(es));
        end
        if (prev >= 0) begin
          n_checks++;
          if (cyc - prev != WORDS + 2) begin
            n_fail++; $display("FAIL b2b period: got %0d want %0d", cyc - prev, WORDS + 2);
          end
        end
        prev = cyc;
      end
    end
    n_checks++;
    if (seen < 3) begin n_fail++; $display("FAIL b2b count: got %0d results want at least 3", seen); end
    in_valid = 1'b0;
    for (int i = 0; i < WORDS + 3 && busy === 1'b1; i++) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    bit saw;
    @(negedge clk);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_reset: got busy=%b ir=%b ov=%b sum=%h cout=%b want 0 1 0 0000 0",
               busy, in_ready, out_valid, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < WORDS + 3; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw = 1'b1;
    end
    out_ready = 1'b0;
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL aborted_result: got out_valid=1 want never asserted"); end
    run_txn(16'h0F0F, 16'h00F1, 1'b0, 1, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      run_txn(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2), "random");
  endtask

  task automatic test_words1();
    logic [W1-1:0] xa, xb; bit xc; longint es; bit ec, eo;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin xa = 8'hFF; xb = 8'h01; xc = 1'b0; end
      else if (i == 1) begin xa = 8'h7F; xb = 8'h00; xc = 1'b1; end
      else begin xa = W1'($urandom); xb = W1'($urandom); xc = 1'($urandom); end
      model(W1, longint'(xa), longint'(xb), xc, es, ec, eo);
      @(negedge clk);
      in_valid1 = 1'b1; a1 = xa; b1 = xb; cin1 = xc;
      @(negedge clk);
      in_valid1 = 1'b0;
      n_checks++;
      if (out_valid1 !== 1'b0 || busy1 !== 1'b1) begin
        n_fail++; $display("FAIL words1 add_state: got ov=%b busy=%b want 0 1", out_valid1, busy1);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid1 !== 1'b1 || sum1 !== W1'(es) || cout1 !== ec || ovf1 !== eo) begin
        n_fail++;
        $display("FAIL words1 result: got ov=%b sum=%h cout=%b ovf=%b want ov=1 sum=%h cout=%b ovf=%b",
                 out_valid1, sum1, cout1, ovf1, W1'(es), ec, eo);
      end
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_inputs();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    test_words1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
